vga_multi_disc_engine: RTL and testbench
========================================

// Module: vga_multi_disc_engine
// PURPOSE
//  Parametrised N-disc renderer for the VGA path, clocked by one system clock.
//  Disc descriptors (centre, radius, colour, enable) are runtime-programmable.
//  Per accepted pixel, one disc is tested per cycle through a 2-stage dx^2+dy^2 <= r^2 pipeline.
//  The highest-priority hit drives registered 1-bit RGB; sits between the VGA timing generator and pins.
// PARAMETERS
//  N_DISCS  3   number of disc descriptors, >=1; priority: lower index on top
//  COORD_W  10  width of pos_h/pos_v, centre coordinates and radius
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  rst_n      in   1          asynchronous active-low reset
//  pix_valid  in   1          pixel strobe; pos_h/pos_v/blank sampled when accepted
//  pos_h      in   COORD_W    pixel x
//  pos_v      in   COORD_W    pixel y
//  blank      in   1          1 = outside active video; pixel renders black
//  cfg_we     in   1          descriptor write strobe
//  cfg_idx    in   IDX_W      descriptor index, IDX_W = max(1,$clog2(N_DISCS))
//  cfg_x      in   COORD_W    centre x
//  cfg_y      in   COORD_W    centre y
//  cfg_r      in   COORD_W    radius
//  cfg_color  in   3          {r,g,b} colour of disc
//  cfg_en     in   1          disc enable
//  cfg_ready  out  1          = ~busy; writes accepted only when high
//  ovr_clr    in   1          clears overrun
//  red/green/blue out 1 each  registered pixel colour
//  rgb_valid  out  1          1-cycle pulse when red/green/blue update
//  busy       out  1          pixel in flight
//  overrun    out  1          sticky: pix_valid arrived while busy
// BEHAVIOUR
//  Reset (async): FSM=IDLE; all descriptors x=y=r=0, color=0, en=0; red/green/blue=0,
//   rgb_valid=0, busy=0, overrun=0, pipeline hit flags cleared. Mid-pixel reset aborts, no rgb_valid.
//  FSM IDLE -> SCAN -> DRAIN -> OUT -> IDLE.
//   IDLE: pix_valid=1 at edge E0 latches pos/blank, idx=0, busy=1, -> SCAN.
//   SCAN: one descriptor issued per cycle, idx 0..N_DISCS-1 over N_DISCS edges, then -> DRAIN.
//   DRAIN: 2 cycles to empty the pipeline. OUT: one cycle, then -> IDLE, busy=0.
//  Stage1: dx=|pos_h-x|, dy=|pos_v-y| (COORD_W bits, unsigned magnitude).
//  Stage2: d2=dx*dx+dy*dy (2*COORD_W+1 bits), r2=r*r (2*COORD_W bits);
//   hit = en && (d2 <= r2). No truncation anywhere; r=0 hits only the exact centre.
//  Winner = lowest-index hit; colour = its cfg_color; no hit -> 000; latched blank=1 -> 000.
//  red/green/blue and rgb_valid=1 registered at edge E0+N_DISCS+3 (latency L=N_DISCS+3);
//   colour holds until the next update.
//  pix_valid while busy=1: pixel dropped, overrun<=1. overrun stays set until ovr_clr=1.
//   ovr_clr and a new overrun event in the same cycle: overrun=1.
//  pix_valid in the OUT cycle is dropped; acceptance only in IDLE.
//  Config: cfg_we && cfg_ready && cfg_idx<N_DISCS writes all fields of that descriptor at the edge.
//   Otherwise the write is ignored, with no error flag.
//   Descriptors are therefore stable for the whole scan.
//  Simultaneous cfg_we and pix_valid in IDLE: both take effect.
//   The scan sees the new descriptor, since it is read at issue, 1+ cycles later.
// TESTING
//  1 reset -> all outputs 0, cfg_ready=1; write disc0 (100,100,r=10,col=100,en)
//    pixel (105,105) -> rgb=100, rgb_valid exactly N_DISCS+3 clocks after accept.
//  2 overlap: disc0 col=100 and disc2 col=001 both covering (50,50)
//    -> 100; disable disc0 -> 001; blank=1 -> 000.
//  3 boundary: centre (200,200), r=5: (205,200) hit; (204,204) miss (d2=32>25);
//    r=0 at centre hit, 1 px away miss; extremes (0,0) vs (1023,1023), r=1023 -> no overflow, miss.
//  4 pix_valid pulsed again 2 cycles after accept -> dropped, overrun=1, first pixel correct;
//    ovr_clr -> overrun=0; cfg_we while busy and cfg_idx=N_DISCS -> descriptors unchanged.
//  5 rst_n asserted mid-SCAN -> outputs 0 immediately, no rgb_valid; next pixel after release renders correctly.
//  6 back-to-back pixels every L+1 clocks across a 640-pixel line vs a golden model: zero mismatches, overrun=0.

Source files
------------

// File: rtl/vga_multi_disc_engine.sv
// N-disc renderer: each accepted pixel is tested against every disc descriptor, one per cycle,
// through a two-stage distance pipeline; the lowest-index hit sets the registered 1-bit RGB.
module vga_multi_disc_engine #(
  parameter int N_DISCS = 3,
  parameter int COORD_W = 10,
  parameter int IDX_W   = (N_DISCS > 1) ? $clog2(N_DISCS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] pos_h,
  input  logic [COORD_W-1:0] pos_v,
  input  logic               blank,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic [COORD_W-1:0] cfg_r,
  input  logic [2:0]         cfg_color,
  input  logic               cfg_en,
  output logic               cfg_ready,
  input  logic               ovr_clr,
  output logic               red,
  output logic               green,
  output logic               blue,
  output logic               rgb_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int D2_W = 2*COORD_W + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, OUT} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               drain_q, drain_d;
  logic               accept;

  logic [COORD_W-1:0] discX_q [N_DISCS];
  logic [COORD_W-1:0] discY_q [N_DISCS];
  logic [COORD_W-1:0] discR_q [N_DISCS];
  logic [2:0]         discCol_q [N_DISCS];
  logic               discEn_q [N_DISCS];

  logic [COORD_W-1:0] posH_q, posV_q;
  logic               blank_q;

  logic [COORD_W-1:0] dx1_q, dy1_q, r1_q;
  logic [2:0]         col1_q;
  logic               en1_q, v1_q;

  logic               hit2_q, v2_q;
  logic [2:0]         col2_q;

  logic               found_q;
  logic [2:0]         winCol_q;

  assign busy      = (state_q != IDLE);
  assign cfg_ready = ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pix_valid) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == IDX_W'(N_DISCS - 1)) begin
          drain_d = 1'b0;
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q) state_d = OUT;
        else         drain_d = 1'b1;
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writes are only legal while idle, so the scan always sees a stable descriptor set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DISCS; i++) begin
        discX_q[i]   <= '0;
        discY_q[i]   <= '0;
        discR_q[i]   <= '0;
        discCol_q[i] <= '0;
        discEn_q[i]  <= 1'b0;
      end
    end else if (cfg_we && cfg_ready) begin
      for (int i = 0; i < N_DISCS; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          discX_q[i]   <= cfg_x;
          discY_q[i]   <= cfg_y;
          discR_q[i]   <= cfg_r;
          discCol_q[i] <= cfg_color;
          discEn_q[i]  <= cfg_en;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      posH_q  <= '0;
      posV_q  <= '0;
      blank_q <= 1'b0;
    end else if (accept) begin
      posH_q  <= pos_h;
      posV_q  <= pos_v;
      blank_q <= blank;
    end
  end

  logic [COORD_W-1:0] selX, selY, dxNext, dyNext;
  assign selX   = discX_q[idx_q];
  assign selY   = discY_q[idx_q];
  assign dxNext = (posH_q >= selX) ? (posH_q - selX) : (selX - posH_q);
  assign dyNext = (posV_q >= selY) ? (posV_q - selY) : (selY - posV_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx1_q  <= '0;
      dy1_q  <= '0;
      r1_q   <= '0;
      col1_q <= '0;
      en1_q  <= 1'b0;
      v1_q   <= 1'b0;
    end else begin
      dx1_q  <= dxNext;
      dy1_q  <= dyNext;
      r1_q   <= discR_q[idx_q];
      col1_q <= discCol_q[idx_q];
      en1_q  <= discEn_q[idx_q];
      v1_q   <= (state_q == SCAN);
    end
  end

  // Operands are zero-extended before multiplying so the squares keep every bit.
  logic [2*COORD_W-1:0] dxSq, dySq, rSq;
  logic [D2_W-1:0]      d2;
  logic                 hitNext;
  assign dxSq    = {{COORD_W{1'b0}}, dx1_q} * {{COORD_W{1'b0}}, dx1_q};
  assign dySq    = {{COORD_W{1'b0}}, dy1_q} * {{COORD_W{1'b0}}, dy1_q};
  assign rSq     = {{COORD_W{1'b0}}, r1_q} * {{COORD_W{1'b0}}, r1_q};
  assign d2      = {1'b0, dxSq} + {1'b0, dySq};
  assign hitNext = en1_q && (d2 <= {1'b0, rSq});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit2_q <= 1'b0;
      col2_q <= '0;
      v2_q   <= 1'b0;
    end else begin
      hit2_q <= hitNext;
      col2_q <= col1_q;
      v2_q   <= v1_q;
    end
  end

  // Discs arrive in index order, so the first recorded hit is the top-priority one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found_q  <= 1'b0;
      winCol_q <= '0;
    end else if (accept) begin
      found_q  <= 1'b0;
      winCol_q <= '0;
    end else if (v2_q && hit2_q && !found_q) begin
      found_q  <= 1'b1;
      winCol_q <= col2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red       <= 1'b0;
      green     <= 1'b0;
      blue      <= 1'b0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= (state_q == OUT);
      if (state_q == OUT) begin
        {red, green, blue} <= blank_q ? 3'b000 : winCol_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                overrun <= 1'b0;
    else if (pix_valid && busy) overrun <= 1'b1;
    else if (ovr_clr)          overrun <= 1'b0;
  end

endmodule

// File: tb/tb_vga_multi_disc_engine.sv
// Directed bench for vga_multi_disc_engine: a table of config writes and pixels with
// hand-computed colours, hand-written overrun/config/reset sequences and a golden-model line sweep.
module tb_vga_multi_disc_engine;

  localparam int N = 3;
  localparam int L = N + 3;

  logic       clk, rst_n, pix_valid, blank, cfg_we, cfg_en, ovr_clr;
  logic [9:0] pos_h, pos_v, cfg_x, cfg_y, cfg_r;
  logic [1:0] cfg_idx;
  logic [2:0] cfg_color;
  logic       cfg_ready, red, green, blue, rgb_valid, busy, overrun;

  int passCount = 0;
  int totalCount = 0;

  vga_multi_disc_engine #(.N_DISCS(N), .COORD_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pos_h(pos_h), .pos_v(pos_v),
    .blank(blank), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_r(cfg_r), .cfg_color(cfg_color), .cfg_en(cfg_en), .cfg_ready(cfg_ready),
    .ovr_clr(ovr_clr), .red(red), .green(green), .blue(blue), .rgb_valid(rgb_valid),
    .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         isCfg;
    int         idx;
    int         x;
    int         y;
    int         r;
    logic [2:0] col;
    bit         en;
    int         h;
    int         v;
    bit         blk;
    logic [2:0] expCol;
    string      name;
  } vec_t;

  vec_t vecs[$];

  int         shX [N];
  int         shY [N];
  int         shR [N];
  logic [2:0] shCol [N];
  bit         shEn [N];

  function automatic void addCfg(int idx, int x, int y, int r, logic [2:0] col, bit en);
    vec_t t;
    t.isCfg = 1'b1; t.idx = idx; t.x = x; t.y = y; t.r = r; t.col = col; t.en = en;
    t.h = 0; t.v = 0; t.blk = 1'b0; t.expCol = 3'b000; t.name = "cfg";
    vecs.push_back(t);
  endfunction

  function automatic void addPix(string name, int h, int v, bit blk, logic [2:0] expCol);
    vec_t t;
    t.isCfg = 1'b0; t.idx = 0; t.x = 0; t.y = 0; t.r = 0; t.col = 3'b000; t.en = 1'b0;
    t.h = h; t.v = v; t.blk = blk; t.expCol = expCol; t.name = name;
    vecs.push_back(t);
  endfunction

  function automatic logic [2:0] modelColor(int h, int v);
    longint dx, dy;
    for (int i = 0; i < N; i++) begin
      dx = longint'(h - shX[i]);
      dy = longint'(v - shY[i]);
      if (shEn[i] && (dx*dx + dy*dy <= longint'(shR[i]) * longint'(shR[i]))) return shCol[i];
    end
    return 3'b000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else             passCount++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeDisc(input int idx, input int x, input int y, input int r,
                           input logic [2:0] col, input bit en);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_x = 10'(x); cfg_y = 10'(y); cfg_r = 10'(r);
    cfg_color = col; cfg_en = en;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic waitRgb(output logic [2:0] col, output int cyc);
    cyc = -1;
    col = 3'b000;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (rgb_valid) begin
        cyc = c;
        col = {red, green, blue};
        break;
      end
    end
  endtask

  task automatic renderPixel(input int h, input int v, input bit blk,
                             output logic [2:0] col, output int lat);
    pos_h = 10'(h); pos_v = 10'(v); blank = blk; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    waitRgb(col, lat);
  endtask

  task automatic applyStimulus(input vec_t t);
    logic [2:0] col;
    int lat;
    if (t.isCfg) begin
      writeDisc(t.idx, t.x, t.y, t.r, t.col, t.en);
    end else begin
      renderPixel(t.h, t.v, t.blk, col, lat);
      checkOutput({t.name, " colour"}, 32'(col), 32'(t.expCol));
      checkOutput({t.name, " latency"}, lat, L);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] col;
    int lat, cyc, pulses;

    rst_n = 1'b0; pix_valid = 1'b0; blank = 1'b0; cfg_we = 1'b0; cfg_en = 1'b0;
    ovr_clr = 1'b0; pos_h = '0; pos_v = '0; cfg_x = '0; cfg_y = '0; cfg_r = '0;
    cfg_idx = '0; cfg_color = '0;

    #2;
    checkOutput("reset outputs", 32'({red, green, blue, rgb_valid, busy, overrun, cfg_ready}),
                32'(7'b0000001));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("post-reset idle", 32'({red, green, blue, rgb_valid, busy, overrun, cfg_ready}),
                32'(7'b0000001));

    addCfg(0, 100, 100, 10, 3'b100, 1'b1);
    addPix("t1_hit", 105, 105, 1'b0, 3'b100);
    addCfg(0, 50, 50, 10, 3'b100, 1'b1);
    addCfg(1, 0, 0, 0, 3'b010, 1'b0);
    addCfg(2, 55, 55, 20, 3'b001, 1'b1);
    addPix("t2_top", 50, 50, 1'b0, 3'b100);
    addPix("t2_low_only", 65, 60, 1'b0, 3'b001);
    addPix("t2_none", 70, 70, 1'b0, 3'b000);
    addCfg(0, 50, 50, 10, 3'b100, 1'b0);
    addPix("t2_dis0", 50, 50, 1'b0, 3'b001);
    addPix("t2_blank", 50, 50, 1'b1, 3'b000);
    addCfg(2, 55, 55, 20, 3'b001, 1'b0);
    addCfg(1, 200, 200, 5, 3'b010, 1'b1);
    addPix("t3_edge", 205, 200, 1'b0, 3'b010);
    addPix("t3_diag_miss", 204, 204, 1'b0, 3'b000);
    addPix("t3_left_edge", 195, 200, 1'b0, 3'b010);
    addPix("t3_below_miss", 200, 206, 1'b0, 3'b000);
    addCfg(1, 200, 200, 0, 3'b010, 1'b1);
    addPix("t3_r0_centre", 200, 200, 1'b0, 3'b010);
    addPix("t3_r0_right", 201, 200, 1'b0, 3'b000);
    addPix("t3_r0_up", 200, 199, 1'b0, 3'b000);
    addCfg(1, 200, 200, 0, 3'b010, 1'b0);
    addCfg(0, 0, 0, 1023, 3'b111, 1'b1);
    addPix("t3_far_corner", 1023, 1023, 1'b0, 3'b000);
    addPix("t3_axis_equal", 1023, 0, 1'b0, 3'b111);
    addPix("t3_diag_in", 723, 723, 1'b0, 3'b111);
    addPix("t3_diag_out", 724, 723, 1'b0, 3'b000);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Overrun: a second strobe two cycles into the scan is dropped and flagged.
    writeDisc(0, 100, 100, 10, 3'b100, 1'b1);
    pos_h = 10'd105; pos_v = 10'd105; blank = 1'b0; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    pos_h = 10'd0; pos_v = 10'd0; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    checkOutput("t4 overrun set", 32'({overrun, busy}), 32'(2'b11));
    waitRgb(col, cyc);
    checkOutput("t4 first colour", 32'(col), 32'(3'b100));
    checkOutput("t4 first latency", cyc + 2, L);
    pulses = 0;
    for (int c = 0; c < L + 3; c++) begin
      tick();
      if (rgb_valid) pulses++;
    end
    checkOutput("t4 dropped pixel pulses", pulses, 0);
    checkOutput("t4 overrun sticky", 32'({overrun, busy}), 32'(2'b10));
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    checkOutput("t4 overrun cleared", 32'(overrun), 32'(1'b0));

    pos_h = 10'd105; pos_v = 10'd105; pix_valid = 1'b1;
    tick();
    ovr_clr = 1'b1;
    tick();
    pix_valid = 1'b0; ovr_clr = 1'b0;
    checkOutput("t4 set beats clear", 32'(overrun), 32'(1'b1));
    waitRgb(col, cyc);
    checkOutput("t4 second pixel colour", 32'(col), 32'(3'b100));
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;

    pos_h = 10'd105; pos_v = 10'd105; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    checkOutput("t4 cfg_ready busy", 32'(cfg_ready), 32'(1'b0));
    writeDisc(0, 500, 500, 1, 3'b011, 1'b1);
    waitRgb(col, cyc);
    checkOutput("t4 busy-write pixel", 32'(col), 32'(3'b100));
    writeDisc(3, 105, 105, 0, 3'b011, 1'b1);
    renderPixel(105, 105, 1'b0, col, lat);
    checkOutput("t4 descriptors unchanged", 32'(col), 32'(3'b100));
    renderPixel(500, 500, 1'b0, col, lat);
    checkOutput("t4 busy-write ignored", 32'(col), 32'(3'b000));

    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_x = 10'd100; cfg_y = 10'd100; cfg_r = 10'd10;
    cfg_color = 3'b110; cfg_en = 1'b1;
    pos_h = 10'd105; pos_v = 10'd105; pix_valid = 1'b1;
    tick();
    cfg_we = 1'b0; pix_valid = 1'b0;
    waitRgb(col, cyc);
    checkOutput("t4 same-cycle cfg colour", 32'(col), 32'(3'b110));
    checkOutput("t4 same-cycle cfg latency", cyc, L);

    // Reset in the middle of a scan aborts the pixel with no output pulse.
    pos_h = 10'd105; pos_v = 10'd105; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("t5 reset outputs", 32'({red, green, blue, rgb_valid, busy, overrun, cfg_ready}),
                32'(7'b0000001));
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < L + 4; c++) begin
      tick();
      if (rgb_valid) pulses++;
    end
    checkOutput("t5 aborted pixel pulses", pulses, 0);
    renderPixel(105, 105, 1'b0, col, lat);
    checkOutput("t5 cleared descriptors", 32'(col), 32'(3'b000));
    writeDisc(0, 100, 100, 10, 3'b100, 1'b1);
    renderPixel(105, 105, 1'b0, col, lat);
    checkOutput("t5 recovery colour", 32'(col), 32'(3'b100));
    checkOutput("t5 recovery latency", lat, L);

    // Full-line sweep with pixels back to back, compared against the reference model.
    shX[0] = 100; shY[0] = 240; shR[0] = 30;  shCol[0] = 3'b100; shEn[0] = 1'b1;
    shX[1] = 120; shY[1] = 240; shR[1] = 50;  shCol[1] = 3'b010; shEn[1] = 1'b1;
    shX[2] = 400; shY[2] = 240; shR[2] = 200; shCol[2] = 3'b001; shEn[2] = 1'b1;
    for (int i = 0; i < N; i++) writeDisc(i, shX[i], shY[i], shR[i], shCol[i], shEn[i]);
    for (int h = 0; h < 640; h++) begin
      renderPixel(h, 250, 1'b0, col, lat);
      checkOutput($sformatf("t6 pixel %0d colour", h), 32'(col), 32'(modelColor(h, 250)));
      checkOutput($sformatf("t6 pixel %0d latency", h), lat, L);
    end
    checkOutput("t6 overrun", 32'(overrun), 32'(1'b0));

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
